// File: rtl/sayeh_mem_arbiter_if.sv
// Bus bundle for the SAYEH memory arbiter: CPU strobes, DMA port and external memory side.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface sayeh_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_done;
    logic          cpu_gnt;
    logic          dma_gnt;
    logic          bus_err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          MemDataready;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, MemDataready,
        output cpu_rdata, cpu_done, dma_rdata, dma_done,
        output cpu_gnt, dma_gnt, bus_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, MemDataready,
        input  cpu_rdata, cpu_done, dma_rdata, dma_done,
        input  cpu_gnt, dma_gnt, bus_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sayeh_mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter for SAYEH's single memory port.
// One transfer in flight, MemDataready handshake, timeout abort, anti-starvation streak counter.
module sayeh_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int CPU_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic clk,
    input  logic ExternalReset,
    sayeh_mem_arbiter_if.slave bus
);
    localparam int SW = (CPU_STREAK < 1) ? 1 : $clog2(CPU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_STREAK);
    localparam logic [7:0]    TIMEOUT_C  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q;
    logic [7:0]    wait_q;
    logic [7:0]    wait_d;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;
    logic          cpu_done_q;
    logic          dma_done_q;
    logic          cpu_gnt_q;
    logic          dma_gnt_q;
    logic          bus_err_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic cpu_req;
    logic grant_dma;
    logic grant_cpu;

    // DMA wins when alone, or when the CPU has used up its streak while DMA waited.
    always_comb begin
        cpu_req   = bus.cpu_rd | bus.cpu_wr;
        grant_dma = bus.dma_req && (!cpu_req || (streak_q == STREAK_MAX));
        grant_cpu = cpu_req && !grant_dma;
        wait_d    = wait_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            cpu_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dma) begin
                        mem_addr_q  <= bus.dma_addr;
                        mem_wdata_q <= bus.dma_wdata;
                        mem_read_q  <= !bus.dma_we;
                        mem_write_q <= bus.dma_we;
                        dma_gnt_q   <= 1'b1;
                        streak_q    <= '0;
                        wait_q      <= '0;
                        state_q     <= XFER;
                    end else if (grant_cpu) begin
                        // Read has priority when both CPU strobes are high.
                        mem_addr_q  <= bus.cpu_addr;
                        mem_wdata_q <= bus.cpu_wdata;
                        mem_read_q  <= bus.cpu_rd;
                        mem_write_q <= !bus.cpu_rd;
                        cpu_gnt_q   <= 1'b1;
                        if (!bus.dma_req)
                            streak_q <= '0;
                        else if (streak_q != STREAK_MAX)
                            streak_q <= streak_q + 1'b1;
                        wait_q      <= '0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    if (bus.MemDataready || (wait_d == TIMEOUT_C)) begin
                        if (bus.MemDataready && mem_read_q) begin
                            if (cpu_gnt_q)
                                cpu_rdata_q <= bus.mem_rdata;
                            else
                                dma_rdata_q <= bus.mem_rdata;
                        end
                        bus_err_q   <= !bus.MemDataready;
                        cpu_done_q  <= cpu_gnt_q;
                        dma_done_q  <= dma_gnt_q;
                        cpu_gnt_q   <= 1'b0;
                        dma_gnt_q   <= 1'b0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= GAP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sayeh_mem_arbiter.sv
// Directed + randomized bench for sayeh_mem_arbiter with a transaction-level reference model.
// The memory responder answers after a programmable latency or never (timeout case).
module tb_sayeh_mem_arbiter;
    localparam int AW         = 16;
    localparam int DW         = 16;
    localparam int CPU_STREAK = 4;
    localparam int TIMEOUT    = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sayeh_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sayeh_mem_arbiter #(
        .AW(AW), .DW(DW), .CPU_STREAK(CPU_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .ExternalReset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory responder: storage holds (data ^ pattern) so unwritten cells read as the pattern.
    int mem_lat  = 0;
    bit mem_hang = 1'b0;
    int wcnt     = 0;
    bit [15:0] mem_arr [256];

    function automatic logic [15:0] pat(input logic [7:0] i);
        return {i, ~i};
    endfunction

    always @(posedge clk) begin
        wcnt <= (bus.mem_read | bus.mem_write) ? wcnt + 1 : 0;
        if (bus.mem_write && bus.MemDataready)
            mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata ^ pat(bus.mem_addr[7:0]);
    end

    assign bus.MemDataready = !mem_hang && (bus.mem_read | bus.mem_write) && (wcnt >= mem_lat);
    assign bus.mem_rdata    = (bus.mem_addr == 16'h0040) ? 16'hBEEF
                            : (mem_arr[bus.mem_addr[7:0]] ^ pat(bus.mem_addr[7:0]));

    // Reference model state
    logic [15:0] ref_mem [256];
    int          streak_m = 0;
    logic [15:0] exp_cpu  = '0;
    logic [15:0] exp_dma  = '0;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : ref_mem[a[7:0]];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.cpu_rd  = 1'b0;
        bus.cpu_wr  = 1'b0;
        bus.dma_req = 1'b0;
        bus.dma_we  = 1'b0;
    endtask

    task automatic do_xfer(input bit c_rd, input bit c_wr, input bit d_req, input bit d_we,
                           input logic [15:0] ca, input logic [15:0] cw,
                           input logic [15:0] da, input logic [15:0] dw,
                           input int lat, input bit hang, input string tag);
        bit cpu_r;
        bit win_dma;
        bit win_cpu;
        bit is_rd;
        bit done;
        logic [15:0] a;
        logic [15:0] wd;
        int scyc;
        int bad;
        bus.cpu_rd    = c_rd;
        bus.cpu_wr    = c_wr;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cw;
        bus.dma_req   = d_req;
        bus.dma_we    = d_we;
        bus.dma_addr  = da;
        bus.dma_wdata = dw;
        mem_lat       = lat;
        mem_hang      = hang;
        cpu_r   = c_rd | c_wr;
        win_dma = d_req && (!cpu_r || streak_m == CPU_STREAK);
        win_cpu = cpu_r && !win_dma;
        if (!win_dma && !win_cpu) begin
            cyc();
            cyc();
            chk({tag, "_idle"}, {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.dma_gnt}, 4'b0);
            drop_reqs();
            return;
        end
        if (win_dma) streak_m = 0;
        else streak_m = d_req ? ((streak_m < CPU_STREAK) ? streak_m + 1 : CPU_STREAK) : 0;
        is_rd = win_dma ? !d_we : c_rd;
        a     = win_dma ? da : ca;
        wd    = win_dma ? dw : cw;

        cyc();
        chk({tag, "_gnt"}, {bus.cpu_gnt, bus.dma_gnt}, {win_cpu, win_dma});
        chk({tag, "_addr"}, bus.mem_addr, a);
        if (!is_rd) chk({tag, "_wdata"}, bus.mem_wdata, wd);

        done = 1'b0;
        scyc = 0;
        bad  = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.mem_read | bus.mem_write) begin
                scyc++;
                if (bus.mem_read !== is_rd || bus.mem_write !== !is_rd) bad++;
            end
            cyc();
            if (bus.cpu_done | bus.dma_done) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_strobe_cycles"}, scyc, hang ? TIMEOUT : lat + 1);
        chk({tag, "_strobe_type"}, bad, 0);
        chk({tag, "_done_who"}, {bus.cpu_done, bus.dma_done}, {win_cpu, win_dma});
        chk({tag, "_bus_err"}, bus.bus_err, hang);
        chk({tag, "_released"}, {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.dma_gnt}, 4'b0);

        if (!hang) begin
            if (is_rd && win_cpu) exp_cpu = ref_read(a);
            if (is_rd && win_dma) exp_dma = ref_read(a);
            if (!is_rd) ref_mem[a[7:0]] = wd;
        end
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, exp_cpu);
        chk({tag, "_dma_rdata"}, bus.dma_rdata, exp_dma);

        drop_reqs();
        cyc();
        chk({tag, "_gap"}, {bus.mem_read, bus.mem_write, bus.cpu_done, bus.dma_done, bus.bus_err}, 5'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          prev_s;
        int          g;
        int          t;
        int          last_t;
        int          both;
        logic [2:0]  r;

        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        drop_reqs();
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;

        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_strobes", {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.dma_gnt}, 4'b0);
        chk("reset_pulses", {bus.cpu_done, bus.dma_done, bus.bus_err}, 3'b0);
        chk("reset_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'h0);
        chk("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0);

        do_xfer(1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2, 0, "cpu_rd_beef");
        chk("beef_value", bus.cpu_rdata, 32'hBEEF);
        do_xfer(0, 0, 1, 1, 16'h0000, 16'h0000, 16'h1000, 16'h1234, 0, 0, "dma_wr");
        do_xfer(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 1, 0, "dma_rd_back");
        chk("dma_rd_back_value", bus.dma_rdata, 32'h1234);
        do_xfer(1, 1, 0, 0, 16'h0123, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, "cpu_rdwr");

        for (int it = 0; it < 40; it++) begin
            r = 3'($urandom_range(0, 7));
            do_xfer(r[0], r[1], r[2], 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 3), 0, "rand");
        end

        do_xfer(0, 1, 0, 0, 16'h0055, 16'hCAFE, 16'h0000, 16'h0000, 0, 1, "timeout");
        mem_hang = 1'b0;
        cyc();
        chk("timeout_idle", {bus.mem_read, bus.mem_write, bus.cpu_done, bus.bus_err}, 4'b0);

        // Reset one cycle into a CPU read.
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 16'h0080;
        mem_lat      = 3;
        cyc();
        chk("rstmid_started", bus.mem_read, 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.cpu_rd = 1'b0;
        chk("rstmid_strobes", {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.dma_gnt}, 4'b0);
        chk("rstmid_pulses", {bus.cpu_done, bus.dma_done, bus.bus_err}, 3'b0);
        chk("rstmid_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'h0);
        chk("rstmid_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0);
        streak_m = 0;
        exp_cpu  = '0;
        exp_dma  = '0;
        g = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (bus.cpu_done | bus.mem_read) g++;
        end
        chk("rstmid_no_done", g, 0);

        // Both requesters held high: 4 CPU grants then DMA, 3 cycles apart.
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 16'h0011;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 16'h0022;
        mem_lat      = 0;
        prev_s = 1'b0;
        g      = 0;
        t      = 0;
        last_t = 0;
        both   = 0;
        for (int c = 0; c < 60 && g < 10; c++) begin
            cyc();
            t++;
            if (bus.mem_read && bus.mem_write) both++;
            if ((bus.mem_read | bus.mem_write) && !prev_s) begin
                chk("hold_dma_gnt", bus.dma_gnt, (g % 5) == 4);
                chk("hold_cpu_gnt", bus.cpu_gnt, (g % 5) != 4);
                if (g > 0) chk("hold_spacing", t - last_t, 3);
                last_t = t;
                g++;
            end
            prev_s = bus.mem_read | bus.mem_write;
        end
        chk("hold_grants", g, 10);
        chk("hold_no_double_strobe", both, 0);
        drop_reqs();
        cyc();
        cyc();
        cyc();
        chk("hold_cpu_rdata", bus.cpu_rdata, ref_read(16'h0011));
        chk("hold_dma_rdata", bus.dma_rdata, ref_read(16'h0022));
        chk("hold_idle", {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.dma_gnt}, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
